// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scan FSM states, no-key location encoding and a width helper.
// Used by the scanner and by the game FSM when decoding locations.
package keypad_pkg;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    FRAME_END
  } scan_state_e;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;

  // "No key" is encoded as a location equal to the axis size.
  localparam int NO_KEY_ROW = DEF_ROWS;
  localparam int NO_KEY_COL = DEF_COLS;

  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debouncer: accepts a candidate after DEB_FRAMES identical frames and
// registers the stable location together with one-cycle press/release pulses.
module keypad_debounce import keypad_pkg::*; #(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int LOC_W      = 4,
  parameter int DEB_FRAMES = 4
) (
  input  logic             clk_500k,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             frm_vld_i,
  input  logic [LOC_W-1:0] cand_row_i,
  input  logic [LOC_W-1:0] cand_col_i,
  input  logic             cand_multi_i,
  output logic             key_vld_o,
  output logic [LOC_W-1:0] row_o,
  output logic [LOC_W-1:0] col_o,
  output logic             multi_o,
  output logic             press_o,
  output logic             release_o
);

  localparam int DW = clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0]    CNT_MAX  = DW'(DEB_FRAMES - 1);
  localparam logic [LOC_W-1:0] NONE_ROW = LOC_W'(ROWS);
  localparam logic [LOC_W-1:0] NONE_COL = LOC_W'(COLS);

  logic [LOC_W-1:0] prev_row_q, prev_row_d, prev_col_q, prev_col_d;
  logic [LOC_W-1:0] row_q, row_d, col_q, col_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d, multi_q, multi_d;
  logic             press_q, press_d, rel_q, rel_d;
  logic             same;

  always_comb begin
    prev_row_d = prev_row_q;
    prev_col_d = prev_col_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    vld_d      = vld_q;
    multi_d    = multi_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    same       = (cand_row_i == prev_row_q) && (cand_col_i == prev_col_q);
    if (clr_i) begin
      prev_row_d = NONE_ROW;
      prev_col_d = NONE_COL;
      cnt_d      = '0;
    end else if (frm_vld_i) begin
      prev_row_d = cand_row_i;
      prev_col_d = cand_col_i;
      if (!same) cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + DW'(1);
      if (cnt_d == CNT_MAX && (cand_row_i != row_q || cand_col_i != col_q)) begin
        row_d   = cand_row_i;
        col_d   = cand_col_i;
        vld_d   = (cand_row_i != NONE_ROW);
        multi_d = cand_multi_i;
        press_d = (cand_row_i != NONE_ROW);
        rel_d   = (cand_row_i == NONE_ROW);
      end
    end
  end

  always_ff @(posedge clk_500k or posedge rst) begin
    if (rst) begin
      prev_row_q <= NONE_ROW;
      prev_col_q <= NONE_COL;
      cnt_q      <= '0;
      row_q      <= NONE_ROW;
      col_q      <= NONE_COL;
      vld_q      <= 1'b0;
      multi_q    <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      prev_row_q <= prev_row_d;
      prev_col_q <= prev_col_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      vld_q      <= vld_d;
      multi_q    <= multi_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
    end
  end

  assign key_vld_o = vld_q;
  assign row_o     = row_q;
  assign col_o     = col_q;
  assign multi_o   = multi_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/keypad_scan_deb.sv
// Matrix keypad scanner: one-cold column strobes, synchronised row sampling and one
// resolved key per frame (lowest column, then lowest row) fed to the debouncer.
module keypad_scan_deb import keypad_pkg::*; #(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int LOC_W      = 4,
  parameter int SETTLE     = 3,
  parameter int DEB_FRAMES = 4
) (
  input  logic             clk_500k,
  input  logic             rst,
  input  logic             scan_en,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic             key_valid,
  output logic [LOC_W-1:0] row_loc,
  output logic [LOC_W-1:0] col_loc,
  output logic             multi_key,
  output logic             key_press,
  output logic             key_release
);

  localparam int SW = clog2(SETTLE + 1);
  localparam logic [SW-1:0]    SET_MAX  = SW'(SETTLE - 1);
  localparam logic [LOC_W-1:0] LAST_COL = LOC_W'(COLS - 1);
  localparam logic [LOC_W-1:0] NONE_ROW = LOC_W'(ROWS);
  localparam logic [LOC_W-1:0] NONE_COL = LOC_W'(COLS);

  scan_state_e      state_q, state_d;
  logic [ROWS-1:0]  row_m_q, row_s_q;
  logic             run_q;
  logic [LOC_W-1:0] col_q, col_d;
  logic [SW-1:0]    set_q, set_d;
  logic [LOC_W-1:0] hit_row_q, hit_row_d, hit_col_q, hit_col_d;
  logic [1:0]       hit_cnt_q, hit_cnt_d;
  logic [COLS-1:0]  col_n_q, col_n_d;
  logic [LOC_W-1:0] low_row;
  logic [3:0]       zero_cnt, hit_sum;
  logic             frm_vld;

  always_comb begin
    low_row  = NONE_ROW;
    zero_cnt = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_s_q[r]) begin
        low_row  = LOC_W'(r);
        zero_cnt = zero_cnt + 4'd1;
      end
    end
    hit_sum = {2'b00, hit_cnt_q} + zero_cnt;
  end

  // run_q holds the FSM for one cycle after enable so column 0 gets a full settle window.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    set_d     = set_q;
    hit_row_d = hit_row_q;
    hit_col_d = hit_col_q;
    hit_cnt_d = hit_cnt_q;
    frm_vld   = 1'b0;
    if (!scan_en) begin
      state_d   = DRIVE;
      col_d     = '0;
      set_d     = '0;
      hit_row_d = NONE_ROW;
      hit_col_d = NONE_COL;
      hit_cnt_d = '0;
    end else if (run_q) begin
      case (state_q)
        DRIVE: begin
          if (set_q == SET_MAX) begin
            state_d = SAMPLE;
            set_d   = '0;
          end else begin
            set_d = set_q + SW'(1);
          end
        end
        SAMPLE: begin
          if (zero_cnt != 4'd0 && hit_row_q == NONE_ROW) begin
            hit_row_d = low_row;
            hit_col_d = col_q;
          end
          hit_cnt_d = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
          if (col_q == LAST_COL) begin
            state_d = FRAME_END;
          end else begin
            col_d   = col_q + LOC_W'(1);
            state_d = DRIVE;
          end
        end
        FRAME_END: begin
          frm_vld   = 1'b1;
          state_d   = DRIVE;
          col_d     = '0;
          hit_row_d = NONE_ROW;
          hit_col_d = NONE_COL;
          hit_cnt_d = '0;
        end
        default: state_d = DRIVE;
      endcase
    end
    col_n_d = (scan_en && state_d != FRAME_END) ? ~(COLS'(1) << col_d) : '1;
  end

  always_ff @(posedge clk_500k or posedge rst) begin
    if (rst) begin
      row_m_q   <= '1;
      row_s_q   <= '1;
      run_q     <= 1'b0;
      state_q   <= DRIVE;
      col_q     <= '0;
      set_q     <= '0;
      hit_row_q <= NONE_ROW;
      hit_col_q <= NONE_COL;
      hit_cnt_q <= '0;
      col_n_q   <= '1;
    end else begin
      row_m_q   <= row_n;
      row_s_q   <= row_m_q;
      run_q     <= scan_en;
      state_q   <= state_d;
      col_q     <= col_d;
      set_q     <= set_d;
      hit_row_q <= hit_row_d;
      hit_col_q <= hit_col_d;
      hit_cnt_q <= hit_cnt_d;
      col_n_q   <= col_n_d;
    end
  end

  assign col_n = col_n_q;

  keypad_debounce #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .LOC_W      (LOC_W),
    .DEB_FRAMES (DEB_FRAMES)
  ) u_deb (
    .clk_500k     (clk_500k),
    .rst          (rst),
    .clr_i        (!scan_en),
    .frm_vld_i    (frm_vld),
    .cand_row_i   (hit_row_q),
    .cand_col_i   (hit_col_q),
    .cand_multi_i (hit_cnt_q == 2'd2),
    .key_vld_o    (key_valid),
    .row_o        (row_loc),
    .col_o        (col_loc),
    .multi_o      (multi_key),
    .press_o      (key_press),
    .release_o    (key_release)
  );

endmodule

// File: doc/keypad_scan_deb.md
Name: keypad_scan_deb

Overview:
- Parametrised matrix-keypad scanner for the whack-a-mole board, running on clk_500k.
- Drives one-cold column strobes and synchronises the active-low row returns.
- Resolves one key per scan frame, debounces across frames and presents a stable registered location with press/release event pulses to the game logic.
- Replaces the free-running 4x4 combinational scanner; outputs carry no glitches.

Parameters:
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column strobes (2..8)
- LOC_W, 4, width of row_loc/col_loc; must hold values 0..max(ROWS,COLS)
- SETTLE, 3, clk_500k cycles a column is driven before sampling; must be >=3 to cover the 2-flop synchroniser
- DEB_FRAMES, 4, consecutive identical frames required before the stable result changes (>=1)

Ports:
- clk_500k  in  1  scan clock
- rst  in  1  asynchronous, active-high reset
- scan_en  in  1  1 = scanning enabled; 0 = scanning paused
- row_n  in  ROWS  raw keypad rows, active-low, asynchronous
- col_n  out  COLS  column strobes, one-cold while scanning, all-ones when idle
- key_valid  out  1  a stable key is held
- row_loc  out  LOC_W  stable row index; ROWS when no key
- col_loc  out  LOC_W  stable column index; COLS when no key
- multi_key  out  1  the last accepted frame saw two or more pressed intersections
- key_press  out  1  one-cycle pulse when a new stable key is accepted
- key_release  out  1  one-cycle pulse when the stable state goes from key to none

Behaviour:
- Reset state:
  - col_n = all ones; key_valid = 0; row_loc = ROWS; col_loc = COLS.
  - multi_key, key_press and key_release = 0.
  - FSM in DRIVE at column 0; settle counter, debounce counter and frame accumulators cleared.
  - Synchroniser flops reset to all ones.
- Reset mid-frame discards all partial frame and debounce state.
- Input sync: row_n passes through a 2-flop synchroniser; the sampled value is row_s.
- FSM states:
  - DRIVE: col_n[c] = 0, all other bits 1. The settle counter counts 0..SETTLE-1, then the FSM moves to SAMPLE.
  - SAMPLE: one cycle. col_n holds. row_s is evaluated for column c:
    - If any bit is 0 and no hit is recorded yet this frame, record (lowest zero row index, c).
    - Add the number of zero bits to the hit count, saturating at 2.
    - If c = COLS-1, go to FRAME_END; otherwise c+1 and DRIVE.
  - FRAME_END: one cycle. col_n = all ones. The frame candidate is the recorded hit, or none. Debounce update runs. Then c = 0, accumulators clear, and the FSM returns to DRIVE.
- Frame period = COLS*(SETTLE+1)+1 cycles; 17 at defaults.
- Priority: lowest column first, then lowest row.
- Debounce, evaluated at FRAME_END only:
  - If the candidate equals the previous frame's candidate, the counter increments, saturating at DEB_FRAMES-1. Otherwise the counter becomes 0.
  - When counter = DEB_FRAMES-1 and the candidate differs from the stable value, the stable value takes the candidate.
  - On that update, multi_key takes (hit count >= 2).
  - With DEB_FRAMES = 1, every frame is accepted immediately.
- Events, registered and asserted in the cycle after FRAME_END on a stable change:
  - none -> key, or key A -> key B: key_press = 1 for one cycle.
  - key -> none: key_release = 1 for one cycle.
  - key_press and key_release are never high together.
- Location outputs change in the same cycle as the pulse and are otherwise held.
- scan_en = 0:
  - From the next cycle, col_n = all ones.
  - FSM forced to DRIVE at c = 0; settle counter and accumulators cleared; previous candidate and debounce counter cleared.
  - Stable outputs held, no pulses.
  - When scan_en returns to 1, a full new frame starts.
- Arithmetic: the settle counter is clog2(SETTLE+1) bits and the debounce counter is clog2(DEB_FRAMES+1) bits. Neither wraps.

Decomposition:
- Shared package keypad_pkg:
  - scan state enum (DRIVE, SAMPLE, FRAME_END)
  - NO_KEY encoding constants
  - a clog2 helper
- The game FSM shares keypad_pkg for location decoding.
- Sub-module keypad_debounce: frame candidate in, stable location, multi_key and pulses out. The scanner FSM and synchroniser stay in the top level.

Test Plan:
- Reset: after rst, col_n = 4'b1111, row_loc = 4, col_loc = 4, key_valid = 0. The first DRIVE cycle gives col_n = 4'b1110.
- Single key: hold row 2 low whenever col 1 is strobed, defaults. key_press fires once at the end of the 4th frame (~68 cycles), with row_loc = 2, col_loc = 1, key_valid = 1, multi_key = 0.
- Bounce: toggle the key present/absent on alternate frames for 10 frames. There is no key_press and the outputs stay at 4/4.
- Release: from the stable key at (2,1), release it. key_release fires once after 4 clean frames, then row_loc/col_loc = 4 and key_valid = 0.
- Multi-key: press (3,0) and (1,2) together. The result is row_loc = 3, col_loc = 0, multi_key = 1. Then change directly to (1,2) alone: key_press fires again with the new location, no key_release, and multi_key = 0.
- Pause and reset mid-frame: drop scan_en mid-frame with a key held. col_n goes to all ones next cycle and the outputs are held. Re-enabling restarts at col 0. Asserting rst mid-SAMPLE clears everything immediately, asynchronously.
